// File: rtl/mem_bus_responder.sv
// mem_bus_responder: RAM + MMIO responder on the control-unit memory bus.
// Ports: clk, reset_n, address/data/rden/wren -> q, gpio_in, gpio_out, bus_err.
module mem_bus_responder #(
   parameter int         RAM_DEPTH    = 16384,
   parameter int         PRESCALE     = 4,
   parameter logic [7:0] UNMAPPED_VAL = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] address,
   input  logic [7:0]  data,
   input  logic        rden,
   input  logic        wren,
   output logic [7:0]  q,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic        bus_err
);

   localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [16:0]   RAM_END   = 17'(RAM_DEPTH);
   localparam logic [PW-1:0] PS_MAX    = PW'(PRESCALE - 1);
   localparam logic [12:0]   MMIO_PAGE = 13'h1FE0;

   localparam logic [2:0] R_GPIO_OUT = 3'd0;
   localparam logic [2:0] R_GPIO_IN  = 3'd1;
   localparam logic [2:0] R_TMR_LO   = 3'd2;
   localparam logic [2:0] R_TMR_HI   = 3'd3;
   localparam logic [2:0] R_TMR_CTRL = 3'd4;
   localparam logic [2:0] R_STATUS   = 3'd5;

   logic [7:0]    mem [RAM_DEPTH];

   logic          ram_sel;
   logic          mmio_sel;
   logic          unmapped;
   logic [AW-1:0] ram_idx;
   logic [2:0]    reg_off;
   logic          rd_en;

   logic          wr_gpio;
   logic          wr_ctrl;
   logic          wr_stat;
   logic          rd_lo;

   logic [7:0]    gpio_s1;
   logic [7:0]    gpio_s2;

   logic [PW-1:0] presc;
   logic [15:0]   timer;
   logic [7:0]    hi_shadow;
   logic          tmr_en;
   logic          ovf;

   logic          tick;
   logic          tmr_clr;
   logic          ovf_set;
   logic          ovf_w1c;
   logic          err_set;
   logic          err_w1c;

   logic [7:0]    mmio_val;
   logic [7:0]    rd_val;

   // Address decode
   assign ram_sel  = {1'b0, address} < RAM_END;
   assign mmio_sel = address[15:3] == MMIO_PAGE;
   assign unmapped = !ram_sel && !mmio_sel;
   assign ram_idx  = address[AW-1:0];
   assign reg_off  = address[2:0];

   // A simultaneous write takes the cycle; q is left alone.
   assign rd_en = rden && !wren;

   assign wr_gpio = wren && mmio_sel
                 && reg_off == R_GPIO_OUT;
   assign wr_ctrl = wren && mmio_sel
                 && reg_off == R_TMR_CTRL;
   assign wr_stat = wren && mmio_sel
                 && reg_off == R_STATUS;
   assign rd_lo   = rd_en && mmio_sel
                 && reg_off == R_TMR_LO;

   // Timer events
   assign tick    = tmr_en && presc == PS_MAX;
   assign tmr_clr = wr_ctrl && data[1];
   assign ovf_set = tick && !tmr_clr
                 && timer == 16'hFFFF;
   assign ovf_w1c = wr_stat && data[0];
   assign err_set = (rden || wren) && unmapped;
   assign err_w1c = wr_stat && data[1];

   // RAM array: contents survive reset.
   always_ff @(posedge clk) begin
      if (wren && ram_sel) begin
         mem[ram_idx] <= data;
      end
   end

   // Read mux
   always_comb begin
      mmio_val = 8'h00;
      case (reg_off)
         R_GPIO_OUT: mmio_val = gpio_out;
         R_GPIO_IN:  mmio_val = gpio_s2;
         R_TMR_LO:   mmio_val = timer[7:0];
         R_TMR_HI:   mmio_val = hi_shadow;
         R_TMR_CTRL: mmio_val = {7'b0, tmr_en};
         R_STATUS:   mmio_val = {6'b0, bus_err, ovf};
         default:    mmio_val = 8'h00;
      endcase
   end

   always_comb begin
      rd_val = UNMAPPED_VAL;
      unique case (1'b1)
         ram_sel:  rd_val = mem[ram_idx];
         mmio_sel: rd_val = mmio_val;
         unmapped: rd_val = UNMAPPED_VAL;
      endcase
   end

   // Registered read data and the HI shadow
   // are captured on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q         <= 8'h00;
         hi_shadow <= 8'h00;
      end else if (rd_en) begin
         q <= rd_val;
         if (rd_lo) begin
            hi_shadow <= timer[15:8];
         end
      end
   end

   // GPIO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gpio_out <= 8'h00;
         gpio_s1  <= 8'h00;
         gpio_s2  <= 8'h00;
      end else begin
         gpio_s1 <= gpio_in;
         gpio_s2 <= gpio_s1;
         if (wr_gpio) begin
            gpio_out <= data;
         end
      end
   end

   // Timer enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_en <= 1'b0;
      end else if (wr_ctrl) begin
         tmr_en <= data[0];
      end
   end

   // Prescaler and counter; clear beats a tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
         timer <= 16'h0000;
      end else if (tmr_clr) begin
         presc <= '0;
         timer <= 16'h0000;
      end else if (tmr_en) begin
         if (tick) begin
            presc <= '0;
            timer <= timer + 16'd1;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Sticky flags; a set beats a same-cycle W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf     <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (ovf_w1c) begin
            ovf <= 1'b0;
         end
         if (err_set) begin
            bus_err <= 1'b1;
         end else if (err_w1c) begin
            bus_err <= 1'b0;
         end
      end
   end

endmodule
